uart_rx_frame: RTL and testbench

Parametrised UART receiver, next generation of the fixed 8N1 `uart_rx`. Configurable data width, parity mode and stop-bit count; 2-flop input synchroniser; 3-sample majority vote per bit; false-start rejection; parity, framing and break reporting. Sits between an external serial pin (e.g. LiDAR link) and the byte-consuming logic, same clock domain as `uart_tx`.

---
 rtl/uart_rx_frame.sv | 167 ++++++++++++++++
 tb/tb_uart_rx_frame.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: parametrised UART receiver with 2-flop input synchroniser,
// 3-sample majority vote per bit, false-start rejection and
// parity / framing / break reporting.
module uart_rx_frame #(
    parameter int unsigned CLOCKS_PER_BAUD = 868,
    parameter int unsigned DATA_BITS       = 8,
    parameter int unsigned PARITY          = 0,
    parameter int unsigned STOP_BITS       = 1
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 break_o,
    output logic                 busy_o
);

    localparam int unsigned      CNT_W     = $clog2(CLOCKS_PER_BAUD);
    localparam int unsigned      H         = CLOCKS_PER_BAUD / 2;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLOCKS_PER_BAUD - 1);
    localparam logic [CNT_W-1:0] SAMP_A    = CNT_W'(H - 1);
    localparam logic [CNT_W-1:0] SAMP_B    = CNT_W'(H);
    localparam logic [CNT_W-1:0] DECIDE    = CNT_W'(H + 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state;
    logic                 rx_m;
    logic                 rx_s;
    logic [CNT_W-1:0]     cnt;
    logic [3:0]           idx;
    logic                 samp_a;
    logic                 samp_b;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 stop_err;
    logic                 vote;
    logic                 stop_err_next;
    logic                 par_mismatch;

    // Two-flop synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // Majority vote of the three mid-bit samples and end-of-frame checks
    always_comb begin
        vote          = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
        stop_err_next = stop_err | ~vote;
        if (PARITY == 1)
            par_mismatch = ~(^{shreg, par_bit});
        else if (PARITY == 2)
            par_mismatch = ^{shreg, par_bit};
        else
            par_mismatch = 1'b0;
    end

    // Receive FSM with baud counter and registered outputs.
    // cnt is loaded with 1 on leaving IDLE so that cnt equals the cycle
    // offset from t0 within each bit; the decision at cnt = H+1 then lands
    // exactly on t0 + k*CLOCKS_PER_BAUD + H + 1.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state        <= S_WAIT_IDLE;
            cnt          <= '0;
            idx          <= '0;
            samp_a       <= 1'b1;
            samp_b       <= 1'b1;
            shreg        <= '0;
            par_bit      <= 1'b0;
            stop_err     <= 1'b0;
            data_o       <= '0;
            valid_o      <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            break_o      <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                S_WAIT_IDLE: begin
                    cnt <= '0;
                    if (rx_s)
                        state <= S_IDLE;
                end
                S_IDLE: begin
                    if (!rx_s) begin
                        state    <= S_START;
                        cnt      <= CNT_W'(1);
                        idx      <= '0;
                        par_bit  <= 1'b0;
                        stop_err <= 1'b0;
                        busy_o   <= 1'b1;
                    end else begin
                        cnt <= '0;
                    end
                end
                default: begin
                    cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
                    if (cnt == SAMP_A)
                        samp_a <= rx_s;
                    if (cnt == SAMP_B)
                        samp_b <= rx_s;
                    if (cnt == DECIDE) begin
                        case (state)
                            S_START: begin
                                if (vote) begin
                                    state  <= S_IDLE;
                                    busy_o <= 1'b0;
                                end else begin
                                    state <= S_DATA;
                                end
                            end
                            S_DATA: begin
                                shreg <= {vote, shreg[DATA_BITS-1:1]};
                                if (idx == DATA_LAST) begin
                                    idx   <= '0;
                                    state <= (PARITY != 0) ? S_PARITY : S_STOP;
                                end else begin
                                    idx <= idx + 4'd1;
                                end
                            end
                            S_PARITY: begin
                                par_bit <= vote;
                                state   <= S_STOP;
                            end
                            S_STOP: begin
                                if (idx == STOP_LAST) begin
                                    valid_o      <= 1'b1;
                                    busy_o       <= 1'b0;
                                    data_o       <= shreg;
                                    parity_err_o <= par_mismatch;
                                    frame_err_o  <= stop_err_next;
                                    break_o      <= stop_err_next && (shreg == '0) && !par_bit;
                                    state        <= stop_err_next ? S_WAIT_IDLE : S_IDLE;
                                end else begin
                                    stop_err <= stop_err_next;
                                    idx      <= idx + 4'd1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Testbench for uart_rx_frame: four configurations (8N1 at 868 CPB,
// 8E1 / 8N1 / 7O2 at 16 CPB), table-driven frames, random frames against a
// bit-level reference model, and hand-written glitch/spike/break/reset cases.
module tb_uart_rx_frame;

    localparam int CPB0 = 868;
    localparam int CPB  = 16;
    localparam int H    = CPB / 2;

    logic       clk = 1'b0;
    logic [3:0] rst_l;
    logic [3:0] rx_l;
    int         cyc = 0;

    always #5 clk = ~clk;

    // Cycle counter; read at negedges where it is stable
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] d0, d1, d2;
    logic [6:0] d3;
    logic v0, p0, f0, b0, y0;
    logic v1, p1, f1, b1, y1;
    logic v2, p2, f2, b2, y2;
    logic v3, p3, f3, b3, y3;

    uart_rx_frame #(.CLOCKS_PER_BAUD(CPB0), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk_in(clk), .rst_in(rst_l[0]), .rx(rx_l[0]), .data_o(d0), .valid_o(v0),
        .parity_err_o(p0), .frame_err_o(f0), .break_o(b0), .busy_o(y0));
    uart_rx_frame #(.CLOCKS_PER_BAUD(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk_in(clk), .rst_in(rst_l[1]), .rx(rx_l[1]), .data_o(d1), .valid_o(v1),
        .parity_err_o(p1), .frame_err_o(f1), .break_o(b1), .busy_o(y1));
    uart_rx_frame #(.CLOCKS_PER_BAUD(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u2 (
        .clk_in(clk), .rst_in(rst_l[2]), .rx(rx_l[2]), .data_o(d2), .valid_o(v2),
        .parity_err_o(p2), .frame_err_o(f2), .break_o(b2), .busy_o(y2));
    uart_rx_frame #(.CLOCKS_PER_BAUD(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u3 (
        .clk_in(clk), .rst_in(rst_l[3]), .rx(rx_l[3]), .data_o(d3), .valid_o(v3),
        .parity_err_o(p3), .frame_err_o(f3), .break_o(b3), .busy_o(y3));

    typedef struct {
        int         sel;
        int         cyc;
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
        logic       busy;
    } mon_t;

    mon_t mon_q[$];

    // Record every valid_o pulse of every instance
    always @(negedge clk) begin
        if (v0) mon_q.push_back('{0, cyc, {1'b0, d0}, p0, f0, b0, y0});
        if (v1) mon_q.push_back('{1, cyc, {1'b0, d1}, p1, f1, b1, y1});
        if (v2) mon_q.push_back('{2, cyc, {1'b0, d2}, p2, f2, b2, y2});
        if (v3) mon_q.push_back('{3, cyc, {2'b0, d3}, p3, f3, b3, y3});
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Valid pulse cycle for a frame whose start bit was driven at cycle td
    function automatic int exp_valid(input int td, input int n, input int cpb);
        return td + 2 + (n - 1) * cpb + cpb / 2 + 2;
    endfunction

    // Drive one frame LSB first from a negedge; optional high spike on
    // offsets (spike_mask) within frame bit spike_bit. Returns drive cycle.
    task automatic send_frame(input int sel, input int cpb, input int db,
                              input bit has_par, input logic pbit,
                              input int nstop, input logic [1:0] stops,
                              input logic [8:0] data, input int spike_bit,
                              input logic [31:0] spike_mask, output int td);
        logic [15:0] bits;
        int n;
        bits = '1;
        bits[0] = 1'b0;
        n = 1;
        for (int i = 0; i < db; i++) begin
            bits[n] = data[i];
            n++;
        end
        if (has_par) begin
            bits[n] = pbit;
            n++;
        end
        for (int i = 0; i < nstop; i++) begin
            bits[n] = stops[i];
            n++;
        end
        td = cyc;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < cpb; j++) begin
                rx_l[sel] = bits[i] ^ ((i == spike_bit) && (j < 32) && spike_mask[j]);
                @(negedge clk);
            end
        end
        rx_l[sel] = 1'b1;
    endtask

    task automatic check_frame(input string name, input int sel, input int exp_cyc,
                               input logic [8:0] ed, input logic ep, input logic ef,
                               input logic eb);
        mon_t m;
        chk({name, "/pulses"}, mon_q.size(), 1);
        if (mon_q.size() > 0) begin
            m = mon_q.pop_front();
            chk({name, "/inst"}, m.sel, sel);
            chk({name, "/cycle"}, m.cyc, exp_cyc);
            chk({name, "/data"}, {23'b0, m.data}, {23'b0, ed});
            chk({name, "/parity_err"}, {31'b0, m.perr}, {31'b0, ep});
            chk({name, "/frame_err"}, {31'b0, m.ferr}, {31'b0, ef});
            chk({name, "/break"}, {31'b0, m.brk}, {31'b0, eb});
            chk({name, "/busy_at_valid"}, {31'b0, m.busy}, 32'd0);
        end
        mon_q.delete();
    endtask

    typedef struct {
        logic [7:0] data;
        logic       pbit;
        logic       stop;
        logic [7:0] e_data;
        logic       e_perr;
        logic       e_ferr;
        logic       e_brk;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int td;
        int td2;

        // 8E1 vectors: {data, parity bit, stop bit, expected data, perr, ferr, break}
        tbl[0] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{8'h80, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
        tbl[8] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};

        rst_l = '1;
        rx_l  = '1;
        repeat (3) @(negedge clk);
        chk("reset/data0", {24'b0, d0}, 32'd0);
        chk("reset/valid0", {31'b0, v0}, 32'd0);
        chk("reset/busy1", {31'b0, y1}, 32'd0);
        chk("reset/flags1", {29'b0, p1, f1, b1}, 32'd0);
        rst_l = '0;
        idle(4);
        chk("post_reset/busy", {28'b0, y0, y1, y2, y3}, 32'd0);
        chk("post_reset/valid", {28'b0, v0, v1, v2, v3}, 32'd0);

        // 8N1 at 868 CPB, back-to-back frames
        send_frame(0, CPB0, 8, 1'b0, 1'b0, 1, 2'b11, 9'h0EA, -1, '0, td);
        check_frame("8n1_ea", 0, exp_valid(td, 10, CPB0), 9'h0EA, 1'b0, 1'b0, 1'b0);
        send_frame(0, CPB0, 8, 1'b0, 1'b0, 1, 2'b11, 9'h0A0, -1, '0, td2);
        chk("8n1_b2b_gap", td2 - td, 10 * CPB0);
        idle(CPB);
        check_frame("8n1_a0", 0, exp_valid(td2, 10, CPB0), 9'h0A0, 1'b0, 1'b0, 1'b0);

        // 8E1 vector table
        for (int i = 0; i < 9; i++) begin
            send_frame(1, CPB, 8, 1'b1, tbl[i].pbit, 1, {1'b1, tbl[i].stop},
                       {1'b0, tbl[i].data}, -1, '0, td);
            idle(2 * CPB);
            check_frame($sformatf("tbl%0d", i), 1, exp_valid(td, 11, CPB),
                        {1'b0, tbl[i].e_data}, tbl[i].e_perr, tbl[i].e_ferr, tbl[i].e_brk);
        end

        // Random 8E1 frames against a line-level reference model
        for (int r = 0; r < 30; r++) begin
            logic [7:0] d;
            logic       pb;
            logic       st;
            d  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            pb = ^d;
            if ($urandom_range(0, 3) == 0) pb = ~pb;
            st = ($urandom_range(0, 5) != 0);
            send_frame(1, CPB, 8, 1'b1, pb, 1, {1'b1, st}, {1'b0, d}, -1, '0, td);
            idle($urandom_range(1, 3) * CPB);
            check_frame($sformatf("rand%0d", r), 1, exp_valid(td, 11, CPB), {1'b0, d},
                        ($countones({d, pb}) % 2) != 0, !st, !st && (d == 8'h00) && !pb);
        end

        // Glitch: low for CPB/4 cycles is a false start
        td = cyc;
        rx_l[2] = 1'b0;
        idle(CPB / 4);
        rx_l[2] = 1'b1;
        wait_until(td + 2 + H + 1);
        chk("glitch/busy_before", {31'b0, y2}, 32'd1);
        wait_until(td + 2 + H + 2);
        chk("glitch/busy_after", {31'b0, y2}, 32'd0);
        idle(2 * CPB);
        chk("glitch/pulses", mon_q.size(), 0);
        mon_q.delete();
        send_frame(2, CPB, 8, 1'b0, 1'b0, 1, 2'b11, 9'h03C, -1, '0, td);
        idle(CPB);
        check_frame("glitch_next", 2, exp_valid(td, 10, CPB), 9'h03C, 1'b0, 1'b0, 1'b0);

        // Spike on data bit 0: one sample point is outvoted, two flip the bit
        send_frame(2, CPB, 8, 1'b0, 1'b0, 1, 2'b11, 9'h03C, 1, 32'h0000_0100, td);
        idle(CPB);
        check_frame("spike1", 2, exp_valid(td, 10, CPB), 9'h03C, 1'b0, 1'b0, 1'b0);
        send_frame(2, CPB, 8, 1'b0, 1'b0, 1, 2'b11, 9'h03C, 1, 32'h0000_0300, td);
        idle(CPB);
        check_frame("spike2", 2, exp_valid(td, 10, CPB), 9'h03D, 1'b0, 1'b0, 1'b0);

        // Break: 12 bit times low gives exactly one errored frame
        td = cyc;
        rx_l[2] = 1'b0;
        idle(12 * CPB);
        rx_l[2] = 1'b1;
        check_frame("break", 2, exp_valid(td, 10, CPB), 9'h000, 1'b0, 1'b1, 1'b1);
        idle(2 * CPB);
        chk("break/after_high", mon_q.size(), 0);
        send_frame(2, CPB, 8, 1'b0, 1'b0, 1, 2'b11, 9'h03C, -1, '0, td);
        idle(CPB);
        check_frame("break_next", 2, exp_valid(td, 10, CPB), 9'h03C, 1'b0, 1'b0, 1'b0);

        // 7O2: leave a parity error in the outputs, then reset mid-data
        send_frame(3, CPB, 7, 1'b1, 1'b0, 2, 2'b11, 9'h02B, -1, '0, td);
        idle(CPB);
        check_frame("7o2_pre", 3, exp_valid(td, 11, CPB), 9'h02B, 1'b1, 1'b0, 1'b0);
        rx_l[3] = 1'b0;
        idle(CPB);
        rx_l[3] = 1'b0;
        idle(CPB);
        rx_l[3] = 1'b1;
        idle(CPB / 2);
        chk("rst_mid/busy_before", {31'b0, y3}, 32'd1);
        rst_l[3] = 1'b1;
        #1;
        chk("rst_mid/data", {25'b0, d3}, 32'd0);
        chk("rst_mid/outputs", {27'b0, v3, p3, f3, b3, y3}, 32'd0);
        idle(3);
        rst_l[3] = 1'b0;
        idle(3 * CPB);
        chk("rst_mid/pulses", mon_q.size(), 0);
        chk("rst_mid/busy_after", {31'b0, y3}, 32'd0);
        mon_q.delete();

        send_frame(3, CPB, 7, 1'b1, 1'b1, 2, 2'b01, 9'h05A, -1, '0, td);
        idle(2 * CPB);
        check_frame("7o2_stop2_low", 3, exp_valid(td, 11, CPB), 9'h05A, 1'b0, 1'b1, 1'b0);
        send_frame(3, CPB, 7, 1'b1, 1'b1, 2, 2'b11, 9'h05A, -1, '0, td);
        idle(CPB);
        check_frame("7o2_clean", 3, exp_valid(td, 11, CPB), 9'h05A, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
